// File: rtl/cmd_tag_arbiter_pkg.sv
// Shared types and constants for the AFU command tag arbiter.
package cmd_tag_arbiter_pkg;

  localparam int TAG_COUNT          = 256;
  localparam int CMD_TAG_BITS       = $clog2(TAG_COUNT);
  localparam int NUM_CMD_REQUESTERS = 4;
  localparam int CU_ID_RANGE        = 8;

  typedef logic [CMD_TAG_BITS-1:0] cmd_tag_t;
  typedef logic [CU_ID_RANGE-1:0]  cu_id_t;

  localparam cmd_tag_t INVALID_TAG = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cmd_arb_state_t;

endpackage

// File: rtl/cmd_tag_arbiter_if.sv
// Requester, AFU command and AFU response signals shared by the arbiter and its peers.
interface cmd_tag_arbiter_if
  import cmd_tag_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_CMD_REQUESTERS,
  parameter int PAYLOAD_BITS = 128
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload;
  logic [NUM_REQ*CU_ID_RANGE-1:0]  req_cu_id;
  logic [NUM_REQ-1:0]             req_ready;

  logic                           cmd_valid;
  logic [PAYLOAD_BITS-1:0]        cmd_payload;
  cmd_tag_t                       cmd_tag;
  logic                           cmd_ready;

  logic                           rsp_valid;
  cmd_tag_t                       rsp_tag;
  logic                           rsp_out_valid;
  cmd_tag_t                       rsp_out_tag;
  cu_id_t                         rsp_out_cu_id;

  modport slave (
    input  req_valid, req_payload, req_cu_id, cmd_ready, rsp_valid, rsp_tag,
    output req_ready, cmd_valid, cmd_payload, cmd_tag,
           rsp_out_valid, rsp_out_tag, rsp_out_cu_id
  );

  modport master (
    output req_valid, req_payload, req_cu_id, cmd_ready, rsp_valid, rsp_tag,
    input  req_ready, cmd_valid, cmd_payload, cmd_tag,
           rsp_out_valid, rsp_out_tag, rsp_out_cu_id
  );

endinterface

// File: rtl/cmd_tag_arbiter_tag_free_list.sv
// Circular FIFO of returned command tags; a push and a pop may occur in the same cycle.
module tag_free_list
  import cmd_tag_arbiter_pkg::*;
#(
  parameter int DEPTH = TAG_COUNT - 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push_i,
  input  cmd_tag_t         push_tag_i,
  input  logic             pop_i,
  output cmd_tag_t         pop_tag_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_tag_t         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A full list can still accept a push when the same cycle frees a slot.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  assign pop_tag_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/cmd_tag_arbiter.sv
// Round-robin AFU command arbiter with tag allocation and CU-ID response routing.
// Define CMD_TAG_CHECK_EN to add the in-flight tag bitmap and sticky tag_error.
module cmd_tag_arbiter
  import cmd_tag_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_CMD_REQUESTERS,
  parameter int PAYLOAD_BITS = 128
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  enabled_i,
  cmd_tag_arbiter_if.slave      bus,
  output logic [CMD_TAG_BITS:0] tags_in_flight_o,
  output logic                  drained_o,
  output logic                  tag_error_o
);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = CMD_TAG_BITS + 1;

  cmd_arb_state_t          state_q;
  logic [RR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        fresh_q;
  logic [CNT_W-1:0]        inflight_q;
  logic                    cmd_valid_q;
  logic [PAYLOAD_BITS-1:0] cmd_payload_q;
  cmd_tag_t                cmd_tag_q;
  logic                    rsp_out_valid_q;
  cmd_tag_t                rsp_out_tag_q;
  cu_id_t                  rsp_out_cu_id_q;
  logic                    drained_q;
  cu_id_t                  tag_table_q [TAG_COUNT];

  logic [RR_W:0]           pick;
  logic                    req_any;
  logic [RR_W-1:0]         winner;
  logic                    slot_free, tag_avail, grant;
  logic [NUM_REQ-1:0]      req_ready;
  logic [PAYLOAD_BITS-1:0] win_payload;
  cu_id_t                  win_cu_id;
  logic                    fl_empty, fl_pop;
  cmd_tag_t                fl_pop_tag, alloc_tag;
  logic [CMD_TAG_BITS-1:0] fl_count;
  logic                    rsp_nonzero, rsp_known, rsp_accept;

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [RR_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [RR_W-1:0]    ptr);
    logic [RR_W:0] res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (vld[i] && (((int'(ptr) + k) % NUM_REQ) == i)) res = {1'b1, RR_W'(i)};
      end
    end
    return res;
  endfunction

  assign pick      = rr_pick(bus.req_valid, rr_ptr_q);
  assign req_any   = pick[RR_W];
  assign winner    = pick[RR_W-1:0];
  assign rr_ptr_d  = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
  assign slot_free = !cmd_valid_q || bus.cmd_ready;
  assign tag_avail = (fl_count != '0) || (fresh_q != CNT_W'(TAG_COUNT));
  assign grant     = (state_q == RUN) && slot_free && tag_avail && req_any;
  assign fl_pop    = grant && !fl_empty;
  assign alloc_tag = fl_empty ? fresh_q[CMD_TAG_BITS-1:0] : fl_pop_tag;

  // Requester 0 occupies the most significant slice of the packed buses.
  always_comb begin
    req_ready   = '0;
    win_payload = '0;
    win_cu_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == RR_W'(i)) begin
        req_ready[i] = grant;
        win_payload  = bus.req_payload[(NUM_REQ-1-i)*PAYLOAD_BITS +: PAYLOAD_BITS];
        win_cu_id    = bus.req_cu_id[(NUM_REQ-1-i)*CU_ID_RANGE +: CU_ID_RANGE];
      end
    end
  end

  assign rsp_nonzero = bus.rsp_valid && (bus.rsp_tag != INVALID_TAG);
  assign rsp_accept  = rsp_nonzero && rsp_known;

`ifdef CMD_TAG_CHECK_EN
  logic [TAG_COUNT-1:0] live_q;
  logic                 tag_error_q;

  assign rsp_known = live_q[bus.rsp_tag];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      live_q      <= '0;
      tag_error_q <= 1'b0;
    end else begin
      if (grant)                    live_q[alloc_tag]   <= 1'b1;
      if (rsp_accept)               live_q[bus.rsp_tag] <= 1'b0;
      if (rsp_nonzero && !rsp_known) tag_error_q        <= 1'b1;
    end
  end

  assign tag_error_o = tag_error_q;
`else
  assign rsp_known   = 1'b1;
  assign tag_error_o = 1'b0;
`endif

  tag_free_list #(
    .DEPTH (TAG_COUNT - 1),
    .CNT_W (CMD_TAG_BITS)
  ) u_free_list (
    .clock      (clock),
    .rstn       (rstn),
    .push_i     (rsp_accept),
    .push_tag_i (bus.rsp_tag),
    .pop_i      (fl_pop),
    .pop_tag_o  (fl_pop_tag),
    .empty_o    (fl_empty),
    .count_o    (fl_count)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      fresh_q         <= CNT_W'(1);
      inflight_q      <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_payload_q   <= '0;
      cmd_tag_q       <= INVALID_TAG;
      rsp_out_valid_q <= 1'b0;
      rsp_out_tag_q   <= INVALID_TAG;
      rsp_out_cu_id_q <= '0;
      drained_q       <= 1'b0;
    end else begin
      drained_q <= 1'b0;
      case (state_q)
        IDLE:    if (enabled_i) state_q <= RUN;
        RUN:     if (!enabled_i) state_q <= DRAIN;
        DRAIN: begin
          if (enabled_i) begin
            state_q <= RUN;
          end else if ((inflight_q == '0) && !cmd_valid_q) begin
            state_q   <= IDLE;
            drained_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A grant alongside cmd_ready replaces the outgoing command for back-to-back issue.
      if (grant) begin
        rr_ptr_q      <= rr_ptr_d;
        cmd_valid_q   <= 1'b1;
        cmd_payload_q <= win_payload;
        cmd_tag_q     <= alloc_tag;
      end else if (bus.cmd_ready) begin
        cmd_valid_q   <= 1'b0;
      end

      if (grant && fl_empty) fresh_q <= fresh_q + CNT_W'(1);

      rsp_out_valid_q <= rsp_accept;
      if (rsp_accept) begin
        rsp_out_tag_q   <= bus.rsp_tag;
        rsp_out_cu_id_q <= tag_table_q[bus.rsp_tag];
      end

      if (grant && !rsp_accept)      inflight_q <= inflight_q + CNT_W'(1);
      else if (!grant && rsp_accept) inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (grant) tag_table_q[alloc_tag] <= win_cu_id;
  end

  assign bus.req_ready     = req_ready;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_payload   = cmd_payload_q;
  assign bus.cmd_tag       = cmd_tag_q;
  assign bus.rsp_out_valid = rsp_out_valid_q;
  assign bus.rsp_out_tag   = rsp_out_tag_q;
  assign bus.rsp_out_cu_id = rsp_out_cu_id_q;
  assign tags_in_flight_o  = inflight_q;
  assign drained_o         = drained_q;

endmodule

// File: tb/tb_cmd_tag_arbiter.sv
// Directed self-checking bench for cmd_tag_arbiter (builds with or without CMD_TAG_CHECK_EN).
module tb_cmd_tag_arbiter;
  import cmd_tag_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int PB = 128;

  localparam logic [PB-1:0] P0 = 128'h0000_0000_1111_1111_0000_0000_A000_0000;
  localparam logic [PB-1:0] P1 = 128'h0000_0000_2222_2222_0000_0000_B000_0001;
  localparam logic [PB-1:0] P2 = 128'h0000_0000_3333_3333_0000_0000_C000_0002;
  localparam logic [PB-1:0] P3 = 128'h0000_0000_4444_4444_0000_0000_D000_0003;
  localparam logic [NR*CU_ID_RANGE-1:0] CU_IDS = {8'h05, 8'h11, 8'h22, 8'h33};

  logic                  clock = 1'b0;
  logic                  rstn;
  logic                  enabled;
  logic [CMD_TAG_BITS:0] tif;
  logic                  drained;
  logic                  tag_error;
  logic [PB-1:0]         pl [NR];

  int n_chk  = 0;
  int n_fail = 0;

  cmd_tag_arbiter_if #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) bus ();

  cmd_tag_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) dut (
    .clock            (clock),
    .rstn             (rstn),
    .enabled_i        (enabled),
    .bus              (bus),
    .tags_in_flight_o (tif),
    .drained_o        (drained),
    .tag_error_o      (tag_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    enabled         = 1'b0;
    bus.req_valid   = '0;
    bus.req_payload = {P0, P1, P2, P3};
    bus.req_cu_id   = CU_IDS;
    bus.cmd_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_tag     = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clock);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pl[0] = P0; pl[1] = P1; pl[2] = P2; pl[3] = P3;
    rstn = 1'b0;
    clear_inputs();
    #3;
    chk("rst_cmd_valid", 128'(bus.cmd_valid), 128'(0));
    chk("rst_cmd_tag", 128'(bus.cmd_tag), 128'(0));
    chk("rst_cmd_payload", bus.cmd_payload, 128'(0));
    chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
    chk("rst_rsp_out", 128'({bus.rsp_out_valid, bus.rsp_out_tag, bus.rsp_out_cu_id}), 128'(0));
    chk("rst_status", 128'({tif, drained, tag_error}), 128'(0));

    // Single request from requester 0, then its response routes CU 0x05 back.
    do_reset();
    enabled = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 128'(bus.req_ready), 128'(1));
    tick();
    bus.req_valid = '0;
    #1;
    chk("t1_cmd_valid", 128'(bus.cmd_valid), 128'(1));
    chk("t1_cmd_tag", 128'(bus.cmd_tag), 128'(1));
    chk("t1_cmd_payload", bus.cmd_payload, P0);
    chk("t1_tif", 128'(tif), 128'(1));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk("t1_cmd_clear", 128'(bus.cmd_valid), 128'(0));
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = 8'd1;
    tick();
    bus.rsp_valid = 1'b0;
    chk("t1_rsp_valid", 128'(bus.rsp_out_valid), 128'(1));
    chk("t1_rsp_tag", 128'(bus.rsp_out_tag), 128'(1));
    chk("t1_rsp_cu", 128'(bus.rsp_out_cu_id), 128'(8'h05));
    chk("t1_tif_zero", 128'(tif), 128'(0));
    tick();
    chk("t1_rsp_pulse", 128'(bus.rsp_out_valid), 128'(0));

    // All requesters valid: grants rotate 0,1,2,3,0 with tags 1..5 after a mid-run reset.
    do_reset();
    enabled = 1'b1;
    tick();
    bus.req_valid = 4'b1111;
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_grant", 128'(bus.req_ready), 128'(1) << (i % 4));
      tick();
      chk("t2_tag", 128'(bus.cmd_tag), 128'(i + 1));
      chk("t2_payload", bus.cmd_payload, pl[i % 4]);
    end
    bus.req_valid = '0;
    tick();
    chk("t2_cmd_clear", 128'(bus.cmd_valid), 128'(0));
    chk("t2_tif", 128'(tif), 128'(5));
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = INVALID_TAG;
    tick();
    bus.rsp_valid = 1'b0;
    chk("t2_tag0_no_out", 128'(bus.rsp_out_valid), 128'(0));
    chk("t2_tag0_tif", 128'(tif), 128'(5));

    // Backpressure: command held stable for three stalled cycles, no further grants.
    bus.cmd_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    chk("t3_grant", 128'(bus.req_ready), 128'(4'b0010));
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("t3_no_grant", 128'(bus.req_ready), 128'(0));
      chk("t3_hold_valid", 128'(bus.cmd_valid), 128'(1));
      chk("t3_hold_tag", 128'(bus.cmd_tag), 128'(6));
      chk("t3_hold_payload", bus.cmd_payload, P1);
      tick();
    end
    chk("t3_hold_tag_end", 128'(bus.cmd_tag), 128'(6));
    bus.req_valid = '0;
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk("t3_cmd_clear", 128'(bus.cmd_valid), 128'(0));
    chk("t3_tif", 128'(tif), 128'(6));

    // Tag exhaustion: 255 issues, then a returned tag 17 is the next one granted.
    do_reset();
    enabled = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    bus.cmd_ready = 1'b1;
    repeat (255) tick();
    chk("t4_last_tag", 128'(bus.cmd_tag), 128'(255));
    chk("t4_tif_full", 128'(tif), 128'(255));
    chk("t4_exhausted", 128'(bus.req_ready), 128'(0));
    tick();
    chk("t4_cmd_clear", 128'(bus.cmd_valid), 128'(0));
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = 8'd17;
    #1;
    chk("t4_still_blocked", 128'(bus.req_ready), 128'(0));
    tick();
    bus.rsp_valid = 1'b0;
    #1;
    chk("t4_rsp_cu", 128'(bus.rsp_out_cu_id), 128'(8'h05));
    chk("t4_tif_254", 128'(tif), 128'(254));
    chk("t4_resume", 128'(bus.req_ready), 128'(1));
    tick();
    chk("t4_reuse_tag", 128'(bus.cmd_tag), 128'(17));
    chk("t4_tif_back", 128'(tif), 128'(255));
    chk("t4_blocked_again", 128'(bus.req_ready), 128'(0));
    bus.req_valid = '0;

    // Drain: stop with 3 in flight, return them, drained pulses once and FSM idles.
    do_reset();
    enabled = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    bus.cmd_ready = 1'b1;
    repeat (3) tick();
    bus.req_valid = '0;
    enabled = 1'b0;
    tick();
    chk("t5_tif", 128'(tif), 128'(3));
    chk("t5_cmd_clear", 128'(bus.cmd_valid), 128'(0));
    bus.req_valid = 4'b0001;
    #1;
    chk("t5_no_grant_drain", 128'(bus.req_ready), 128'(0));
    bus.req_valid = '0;
    for (int t = 1; t <= 3; t++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_tag   = cmd_tag_t'(t);
      tick();
      chk("t5_not_drained", 128'(drained), 128'(0));
    end
    bus.rsp_valid = 1'b0;
    chk("t5_tif_zero", 128'(tif), 128'(0));
    tick();
    chk("t5_drained", 128'(drained), 128'(1));
    chk("t5_state_idle", 128'(dut.state_q), 128'(IDLE));
    tick();
    chk("t5_drained_once", 128'(drained), 128'(0));

    // Double return of tag 9.
    do_reset();
    enabled = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    bus.cmd_ready = 1'b1;
    repeat (9) tick();
    bus.req_valid = '0;
    tick();
    chk("t6_tif", 128'(tif), 128'(9));
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = 8'd9;
    tick();
    chk("t6_first_out", 128'(bus.rsp_out_valid), 128'(1));
    chk("t6_first_tif", 128'(tif), 128'(8));
    chk("t6_first_err", 128'(tag_error), 128'(0));
    tick();
    bus.rsp_valid = 1'b0;
`ifdef CMD_TAG_CHECK_EN
    chk("t6_err_set", 128'(tag_error), 128'(1));
    chk("t6_err_tif", 128'(tif), 128'(8));
    chk("t6_err_no_out", 128'(bus.rsp_out_valid), 128'(0));
    tick();
    chk("t6_err_sticky", 128'(tag_error), 128'(1));
`else
    chk("t6_no_err", 128'(tag_error), 128'(0));
    chk("t6_dup_tif", 128'(tif), 128'(7));
    chk("t6_dup_out", 128'(bus.rsp_out_valid), 128'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_tag_arbiter.md
Name: cmd_tag_arbiter

Overview:
- Shares the single AFU command port between NUM_REQ command sources: read, write, restart and WED command buffers.
- Round-robin arbitration, gated by tag availability.
- Allocates a unique command tag per issued command from TAG_COUNT tags; tag 0 (INVALID_TAG) is never issued.
- Records the issuing CU ID per tag and returns it with each response, so the response path can route by cu_id_t.

Parameters:
NUM_REQ, 4, number of command requesters
PAYLOAD_BITS, 128, opaque command payload width (address, size, command code)
TAG_COUNT, 256 (package TAG_COUNT), tag space; usable tags 1..TAG_COUNT-1

Ports:
clock  in  1  clock
rstn  in  1  asynchronous active-low reset
enabled  in  1  1 = issue commands; 0 = stop issuing and drain
req_valid  in  NUM_REQ  requester has a command
req_payload  in  NUM_REQ*PAYLOAD_BITS  per-requester payload, requester 0 in MSBs
req_cu_id  in  NUM_REQ*CU_ID_RANGE  per-requester CU ID
req_ready  out  NUM_REQ  one-hot grant; command accepted this cycle
cmd_valid  out  1  command to AFU valid
cmd_payload  out  PAYLOAD_BITS  granted payload
cmd_tag  out  8  allocated tag
cmd_ready  in  1  AFU consumes cmd this cycle
rsp_valid  in  1  AFU response arrived
rsp_tag  in  8  tag of response
rsp_out_valid  out  1  routed response valid
rsp_out_tag  out  8  registered rsp_tag
rsp_out_cu_id  out  CU_ID_RANGE  CU that issued the tag
tags_in_flight  out  9  allocated, unreturned tag count
drained  out  1  DRAIN complete, zero tags in flight
tag_error  out  1  see Optional Feature

Behaviour:
- Async reset clears all state. Reset values:
  - cmd_valid=0, cmd_payload=0, cmd_tag=0.
  - req_ready=0.
  - rsp_out_valid=0, rsp_out_tag=0, rsp_out_cu_id=0.
  - tags_in_flight=0, drained=0, tag_error=0.
  - RR pointer=0, fresh counter=1, free list empty, state IDLE.
- FSM:
  - IDLE -> RUN when enabled=1.
  - RUN -> DRAIN when enabled=0.
  - DRAIN -> IDLE when tags_in_flight==0 and cmd_valid==0; drained pulses 1 cycle on that transition.
  - DRAIN -> RUN if enabled returns to 1.
- Grant condition, combinational: state==RUN, and output slot free (cmd_valid==0 or cmd_ready==1), and a tag is available.
- Winner = first valid requester at or after the RR pointer, wrapping modulo NUM_REQ. req_ready is asserted for the winner only. The RR pointer moves to winner+1 (mod NUM_REQ) on grant; otherwise it holds.
- Latency: 1 cycle from grant to cmd_valid.
  - cmd_valid, cmd_payload and cmd_tag hold stable until cmd_ready.
  - A new grant in the same cycle as cmd_ready gives back-to-back issue, one command per cycle.
- Tag source: pop the free list if non-empty. Otherwise take the fresh counter (1..TAG_COUNT-1), incrementing it. Tags are exhausted when the free list is empty and fresh==TAG_COUNT.
- On allocation: tag table[tag] <= winner's req_cu_id.
- Response path:
  - rsp_valid pushes rsp_tag onto the free list.
  - Next cycle: rsp_out_valid=1, rsp_out_tag=rsp_tag, rsp_out_cu_id=table[rsp_tag].
  - Responses are accepted in every state and are never backpressured.
- tags_in_flight: +1 on grant, -1 on rsp_valid; unchanged when both occur in the same cycle.
  - A tag returned in cycle N is allocatable from cycle N+1.
  - The free list never overflows: capacity is TAG_COUNT-1.
- At exhaustion (255 in flight): no grants, req_ready=0. Grants resume the cycle after any return.
- rsp_tag==0: ignored, no push, no output.
- Reset mid-operation: all in-flight tags are forgotten; the fresh counter restarts at 1.

Optional Feature:
CMD_TAG_CHECK_EN
- Defined: keep a TAG_COUNT-bit in-flight bitmap, set on allocate and cleared on return.
- A response whose tag bit is clear is a double return or unknown tag. On such a response:
  - tag_error sets and is sticky until reset.
  - The tag is not pushed, tags_in_flight is unchanged, and rsp_out_valid stays 0.
- Undefined: no bitmap; tag_error tied 0; every nonzero rsp_tag is pushed.

Decomposition:
- Shared package additions:
  - CMD_TAG_BITS = $clog2(TAG_COUNT).
  - typedef cmd_tag_t.
  - NUM_CMD_REQUESTERS = 4.
  - typedef cmd_arb_state_t {IDLE, RUN, DRAIN}.
  - INVALID_TAG and cu_id_t are already present.
- Sub-module: tag_free_list, a synchronous FIFO of cmd_tag_t, depth TAG_COUNT-1, with push/pop/empty/count and same-cycle push+pop support.

Test Plan:
- Reset, enabled=1, req 0 alone with cu_id 0x05 -> cmd_tag=1 next cycle; rsp_tag=1 -> rsp_out_cu_id=0x05 one cycle later; tags_in_flight returns to 0.
- All 4 requesters valid, cmd_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; tags 1,2,3,4,5.
- cmd_ready=0 for 3 cycles with one command pending -> payload/tag stable; no further req_ready.
- 255 issues without responses -> req_ready=0; return tag 17 -> next grant gets tag 17.
- enabled 1->0 with 3 in flight, 3 responses -> drained pulses once; state IDLE.
- CMD_TAG_CHECK_EN: return tag 9 twice -> second sets tag_error=1; tags_in_flight unchanged; no rsp_out_valid.
